// File: rtl/fifo_stream_writer_if.sv
// rtl/fifo_stream_writer_if.sv - FIFO write-port bundle (dout/wren/full)
//
// Groups the standard (non-FWFT) FIFO write port:
//   dout : write data, driven by the writer
//   wren : write enable, driven by the writer
//   full : FIFO full flag, driven by the FIFO
// master is the writer side, slave is the FIFO side.

interface fifo_stream_writer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dout;
  logic             wren;
  logic             full;

  modport master (output dout, output wren, input full);
  modport slave  (input dout, input wren, output full);
endinterface

// File: rtl/fifo_stream_writer.sv
// rtl/fifo_stream_writer.sv - throttled incrementing-pattern FIFO writer
//
// Writes a block of `length` words (data_init, data_init+1, ...) into a
// FIFO write port. Each RUN cycle a 32-bit Galois LFSR decides whether a
// write is attempted (low RATE_WIDTH bits <= rate); the attempt becomes a
// write only if the FIFO is not full. An optional watchdog aborts the block
// after TIMEOUT consecutive attempts blocked by full.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a block (only honoured in IDLE)
//   length        : words in block, latched with start (0 -> immediate done)
//   rate          : attempt probability control, latched with start
//   data_init     : first data word, latched with start
//   busy          : high while a block is running
//   done / err    : one-cycle pulses for normal completion / watchdog abort
//   count         : words written in the current or last block
//   fifo (master) : dout / wren / full FIFO write port

module fifo_stream_writer #(
  parameter int          WIDTH      = 8,
  parameter int          LEN_WIDTH  = 16,
  parameter int          RATE_WIDTH = 8,
  parameter logic [31:0] SEED       = 32'h00000001,
  parameter int          TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic [WIDTH-1:0]      data_init,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  count,
  fifo_stream_writer_if.master  fifo
);

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  // Wide enough to hold TIMEOUT itself, since the counter lands on it at abort.
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [31:0]           lfsr_q, lfsr_next;
  logic [LEN_WIDTH-1:0]  len_q, count_q;
  logic [RATE_WIDTH-1:0] rate_q;
  logic [WIDTH-1:0]      init_q, dout_w;
  logic [STALL_W-1:0]    stall_q;
  logic                  done_q, err_q;

  logic attempt, wr, last_wr, stalled, timeout_hit, accept;

  // Right-shifting Galois form: feedback taps applied when bit 0 shifts out.
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

  always_comb begin
    attempt     = (lfsr_q[RATE_WIDTH-1:0] <= rate_q);
    wr          = attempt & ~fifo.full & (state_q == RUN);
    last_wr     = wr & (count_q == (len_q - LEN_WIDTH'(1)));
    stalled     = attempt & fifo.full & (state_q == RUN);
    timeout_hit = 1'b0;
    if (TIMEOUT > 0) begin
      timeout_hit = stalled & (stall_q == STALL_W'(TIMEOUT - 1));
    end
    accept = start & (state_q == IDLE);

    state_d = state_q;
    case (state_q)
      IDLE: if (start && (length != '0)) state_d = RUN;
      RUN:  if (last_wr || timeout_hit)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= SEED;
      len_q   <= '0;
      rate_q  <= '0;
      init_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= (accept & (length == '0)) | last_wr;
      err_q  <= timeout_hit;

      // LFSR only moves while running; it is never reseeded by start.
      if (state_q == RUN) lfsr_q <= lfsr_next;

      if (accept) begin
        len_q   <= length;
        rate_q  <= rate;
        init_q  <= data_init;
        count_q <= '0;
        stall_q <= '0;
      end else if (wr) begin
        count_q <= count_q + LEN_WIDTH'(1);
        stall_q <= '0;
      end else if (stalled && (TIMEOUT > 0)) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end
  end

  // Data is derived from the word count so stalls can never skip or repeat.
  generate
    if (LEN_WIDTH >= WIDTH) begin : g_dout_trunc
      assign dout_w = init_q + count_q[WIDTH-1:0];
    end else begin : g_dout_ext
      assign dout_w = init_q + WIDTH'(count_q);
    end
  endgenerate

  assign fifo.dout = dout_w;
  assign fifo.wren = wr;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fifo_stream_writer.sv
// tb/tb_fifo_stream_writer.sv - directed self-checking bench for fifo_stream_writer

module tb_fifo_stream_writer;

  localparam logic [31:0] MASK = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst, start, start0;
  logic [15:0] length;
  logic [7:0]  rate, data_init;
  logic        busy, done, err, busy0, done0, err0;
  logic [15:0] count, count0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_stream_writer_if #(.WIDTH(8)) bus ();
  fifo_stream_writer_if #(.WIDTH(8)) bus0 ();

  fifo_stream_writer #(
    .WIDTH(8), .LEN_WIDTH(16), .RATE_WIDTH(8), .SEED(32'h00000001), .TIMEOUT(8)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .length(length), .rate(rate),
    .data_init(data_init), .busy(busy), .done(done), .err(err), .count(count),
    .fifo(bus.master)
  );

  fifo_stream_writer #(
    .WIDTH(8), .LEN_WIDTH(16), .RATE_WIDTH(8), .SEED(32'h00000001), .TIMEOUT(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .length(length), .rate(rate),
    .data_init(data_init), .busy(busy0), .done(done0), .err(err0), .count(count0),
    .fifo(bus0.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0]  exp_d;
    logic [31:0] m;
    int n_wr, n_done, n_err, bad, wf, nf_cycles, pm;
    bit got_done;

    rst = 1'b1; start = 1'b0; start0 = 1'b0;
    length = '0; rate = '0; data_init = '0;
    bus.full = 1'b0; bus0.full = 1'b0;

    // Reset state
    repeat (3) step();
    sample();
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_err",   err, 0);
    check("rst_wren",  bus.wren, 0);
    check("rst_count", count, 0);
    check("rst_dout",  bus.dout, 0);
    check("rst_wren0", bus0.wren, 0);
    step(); rst = 1'b0; sample();

    // 1: basic block, every cycle an attempt
    step(); start = 1; length = 4; rate = 8'hFF; data_init = 8'h10; sample();
    check("t1_wren_c0", bus.wren, 0);
    for (int c = 1; c <= 6; c++) begin
      step(); start = 0; sample();
      check($sformatf("t1_wren_c%0d", c), bus.wren, (c <= 4));
      if (c <= 4) check($sformatf("t1_dout_c%0d", c), bus.dout, 8'h10 + c - 1);
      check($sformatf("t1_busy_c%0d", c), busy, (c <= 4));
      check($sformatf("t1_done_c%0d", c), done, (c == 5));
    end
    check("t1_count", count, 4);

    // 2: zero-length block
    step(); start = 1; length = 0; sample();
    check("t2_wren_c0", bus.wren, 0);
    step(); start = 0; sample();
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_wren", bus.wren, 0);
    check("t2_count", count, 0);
    step(); sample();
    check("t2_done_once", done, 0);

    // 3: full stall in cycles 3-5, data wraps through 0xFF
    step(); start = 1; length = 6; rate = 8'hFF; data_init = 8'hFE; sample();
    exp_d = 8'hFE; n_wr = 0; n_done = 0;
    for (int c = 1; c <= 12; c++) begin
      step(); start = 0; bus.full = (c >= 3 && c <= 5); sample();
      if (c >= 3 && c <= 5) check($sformatf("t3_wren_full_c%0d", c), bus.wren, 0);
      if (c == 4) check("t3_dout_hold", bus.dout, 8'h00);
      if (bus.wren) begin
        check($sformatf("t3_dout_w%0d", n_wr), bus.dout, exp_d);
        exp_d++;
        n_wr++;
      end
      if (done) n_done++;
      if (c == 10) check("t3_done_c10", done, 1);
    end
    bus.full = 0;
    check("t3_writes", n_wr, 6);
    check("t3_done_count", n_done, 1);
    check("t3_count", count, 6);

    // 4: watchdog abort after 8 stalled attempts
    step(); start = 1; length = 5; rate = 8'hFF; data_init = 8'h00; bus.full = 1; sample();
    n_wr = 0; n_done = 0;
    for (int c = 1; c <= 11; c++) begin
      step(); start = 0; sample();
      if (bus.wren) n_wr++;
      if (done) n_done++;
      if (c == 8) begin
        check("t4_err_c8", err, 0);
        check("t4_busy_c8", busy, 1);
      end
      if (c == 9) begin
        check("t4_err_c9", err, 1);
        check("t4_busy_c9", busy, 0);
      end
      if (c == 10) check("t4_err_c10", err, 0);
    end
    bus.full = 0;
    check("t4_no_wren", n_wr, 0);
    check("t4_no_done", n_done, 0);
    check("t4_count", count, 0);

    // 5: rate 0x40, 1000 words, random full, watchdog disabled instance
    step(); start0 = 1; length = 1000; rate = 8'h40; data_init = 8'h37; bus0.full = 0; sample();
    exp_d = 8'h37; n_wr = 0; bad = 0; wf = 0; nf_cycles = 0; n_done = 0; n_err = 0;
    got_done = 0;
    for (int c = 0; c < 30000 && !got_done; c++) begin
      step(); start0 = 0; bus0.full = ($urandom_range(0, 3) == 0); sample();
      if (bus0.wren && bus0.full) wf++;
      if (busy0 && !bus0.full) nf_cycles++;
      if (bus0.wren) begin
        if (bus0.dout !== exp_d) bad++;
        exp_d++;
        n_wr++;
      end
      if (err0) n_err++;
      if (done0) begin
        n_done++;
        got_done = 1;
      end
    end
    check("t5_done_seen", got_done, 1);
    repeat (5) begin
      step(); bus0.full = 0; sample();
      if (done0) n_done++;
      if (bus0.wren) n_wr++;
    end
    check("t5_writes", n_wr, 1000);
    check("t5_data_errors", bad, 0);
    check("t5_wren_while_full", wf, 0);
    check("t5_done_count", n_done, 1);
    check("t5_err_count", n_err, 0);
    check("t5_count", count0, 1000);
    pm = (nf_cycles > 0) ? (n_wr * 1000) / nf_cycles : 0;
    check("t5_duty_in_range", (pm >= 170 && pm <= 340), 1);

    // 6: starts while busy are ignored, then reset mid-block
    step(); start = 1; length = 10; rate = 8'hFF; data_init = 8'h20; sample();
    step(); start = 0; sample();
    check("t6_dout_c1", bus.dout, 8'h20);
    step(); start = 1; length = 2; data_init = 8'h80; sample();
    check("t6_wren_c2", bus.wren, 1);
    check("t6_dout_c2", bus.dout, 8'h21);
    check("t6_busy_c2", busy, 1);
    step(); start = 0; rst = 1; sample();
    check("t6_dout_c3", bus.dout, 8'h22);
    check("t6_count_c3", count, 2);
    check("t6_done_c3", done, 0);
    step(); rst = 0; sample();
    check("t6_rst_wren", bus.wren, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_dout", bus.dout, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_err", err, 0);
    step(); sample();
    check("t6_idle_done", done, 0);
    check("t6_idle_err", err, 0);

    // LFSR restarts from SEED: sparse rate makes the attempt pattern visible
    step(); start = 1; length = 4; rate = 8'h01; data_init = 8'h50; sample();
    m = 32'h00000001; n_wr = 0;
    for (int c = 0; c < 40 && n_wr < 4; c++) begin
      step(); start = 0; sample();
      check($sformatf("t6_lfsr_wren_%0d", c), bus.wren, (m[7:0] <= 8'h01));
      if (bus.wren) begin
        check($sformatf("t6_lfsr_dout_%0d", n_wr), bus.dout, 8'h50 + n_wr);
        n_wr++;
      end
      m = m[0] ? ((m >> 1) ^ MASK) : (m >> 1);
    end
    check("t6_lfsr_writes", n_wr, 4);
    step(); sample();
    check("t6_lfsr_done", done, 1);
    check("t6_lfsr_count", count, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
